// File: rtl/avalon_wb_pkg.sv
// avalon_wb_pkg: Wishbone cycle-tag constants and bridge FSM states
package avalon_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  typedef enum logic [1:0] {IDLE, RD, WR, RETRY} state_e;
endpackage

// File: rtl/avalon_to_wb_burst_bridge.sv
// avalon_to_wb_burst_bridge: Avalon-MM burst slave to Wishbone B3 incrementing-burst master
module avalon_to_wb_burst_bridge
  import avalon_wb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int BURST_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        avm_address_i,
  input  logic [DW/8-1:0]      avm_byteenable_i,
  input  logic                 avm_read_i,
  input  logic                 avm_write_i,
  input  logic [DW-1:0]        avm_writedata_i,
  input  logic [BURST_W-1:0]   avm_burstcount_i,
  output logic [DW-1:0]        avm_readdata_o,
  output logic                 avm_readdatavalid_o,
  output logic                 avm_waitrequest_o,
  output logic [AW-1:0]        wbm_adr_o,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [DW/8-1:0]      wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [DW-1:0]        wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i
);
  localparam int BW = DW / 8;
  state_e               state_q;
  logic [AW-1:0]        addr_q;
  logic [BW-1:0]        be_q;
  logic [BURST_W-1:0]   rem_q;
  logic                 is_wr_q;
  logic [DW-1:0]        rdata_q;
  logic [DW-1:0]        wdat_q;
  logic                 rdv_q;
  logic                 in_rd;
  logic                 in_wr;
  logic                 done;
  logic                 retry;
  logic [BURST_W-1:0]   cnt;
  assign in_rd = state_q == RD;
  assign in_wr = state_q == WR;
  assign wbm_cyc_o = in_rd | in_wr;
  assign wbm_stb_o = in_rd | (in_wr & avm_write_i);
  assign wbm_we_o  = in_wr;
  assign wbm_adr_o = addr_q;
  assign wbm_dat_o = in_wr ? avm_writedata_i : wdat_q;
  assign wbm_sel_o = in_wr ? avm_byteenable_i : be_q;
  assign wbm_cti_o = rem_q == BURST_W'(1) ? CTI_EOB : CTI_INCR;
  assign wbm_bte_o = BTE_LINEAR;
  assign done  = wbm_stb_o & (wbm_ack_i | wbm_err_i);
  assign retry = wbm_stb_o & wbm_rty_i & ~(wbm_ack_i | wbm_err_i);
  assign cnt   = avm_burstcount_i == '0 ? BURST_W'(1) : avm_burstcount_i;
  assign avm_waitrequest_o   = ~rst_n | ~((state_q == IDLE & avm_read_i) | (in_wr & done));
  assign avm_readdata_o      = rdata_q;
  assign avm_readdatavalid_o = rdv_q;
  // Burst FSM: capture the command, step address/count per completed beat, one-cycle retry gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      rem_q   <= BURST_W'(1);
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      wdat_q  <= '0;
      rdv_q   <= 1'b0;
    end else begin
      rdv_q <= in_rd & done;
      case (state_q)
        IDLE: if (avm_read_i | avm_write_i) begin
          addr_q  <= avm_address_i;
          be_q    <= avm_byteenable_i;
          rem_q   <= cnt;
          is_wr_q <= ~avm_read_i;
          state_q <= avm_read_i ? RD : WR;
        end
        RD, WR: if (done) begin
          addr_q <= addr_q + AW'(BW);
          rem_q  <= rem_q - BURST_W'(1);
          if (in_rd) rdata_q <= wbm_dat_i;
          if (in_wr) wdat_q <= avm_writedata_i;
          if (rem_q == BURST_W'(1)) state_q <= IDLE;
        end else if (retry) begin
          state_q <= RETRY;
        end
        default: state_q <= is_wr_q ? WR : RD;
      endcase
    end
  end
endmodule
